// File: rtl/alu_pkg.sv
// Shared opcode encodings, controller state encoding and opcode legality check
// for the shared-ALU controller.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= ALU_SLTU;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational pipeline ALU; shift amount is b[4:0], SLT/SLTU return 0 or 1.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_control,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, a < b};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one ALU between two requesters.
//   state | meaning
//   IDLE  | arbitrate, accept one request into the operand registers
//   EXEC  | ALU runs on operand registers, outputs captured into response regs
//   RESP  | rsp_valid held until rsp_ready
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OPC_W-1:0]  req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OPC_W-1:0]  req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  state_t             state, state_next;
  logic               last_grant;
  logic               grant0, grant1;
  logic [DATA_W-1:0]  opr_a, opr_b;
  logic [OPC_W-1:0]   opr_op;
  logic               opr_id;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero;

  // On contention the requester that did not win last time gets the ALU.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0_ready | req1_ready) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      opr_a      <= '0;
      opr_b      <= '0;
      opr_op     <= '0;
      opr_id     <= 1'b0;
    end else if (req0_ready | req1_ready) begin
      last_grant <= req1_ready;
      opr_id     <= req1_ready;
      opr_a      <= req1_ready ? req1_a  : req0_a;
      opr_b      <= req1_ready ? req1_b  : req0_b;
      opr_op     <= req1_ready ? req1_op : req0_op;
    end
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .a           (opr_a),
    .b           (opr_b),
    .alu_control (opr_op),
    .result      (alu_result),
    .zero        (alu_zero)
  );

  // Illegal opcodes discard the ALU output entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id     <= opr_id;
      rsp_result <= is_legal_op(opr_op) ? alu_result : '0;
      rsp_zero   <= is_legal_op(opr_op) & alu_zero;
      rsp_err    <= ~is_legal_op(opr_op);
    end
  end

endmodule
